// File: rtl/stage_if.sv
// rtl/stage_if.sv - instruction fetch stage with byte-wide memory port and direct-mapped I-cache
module stage_if #(
    parameter int          IDX_W    = 6,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        br_wait,
    input  logic        br_done,
    input  logic [31:0] br_target,
    input  logic        mem_grant,
    input  logic [7:0]  mem_rdata,
    output logic        mem_re,
    output logic [31:0] mem_addr,
    output logic        if_valid,
    output logic [31:0] pc,
    output logic [31:0] inst
);

    localparam int LINES = 1 << IDX_W;
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MISS = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [31:0] fetch_pc;
    logic [2:0]  issue_cnt;
    logic [2:0]  recv_cnt;
    logic        rd_pend;
    logic [31:0] asm_word;

    logic [LINES-1:0] line_valid;
    logic [TAG_W-1:0] tag_mem [LINES];
    logic [31:0]      data_mem [LINES];

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             slot_free;
    logic             hit;
    logic             lookup;
    logic             byte3_now;
    logic             word_ready;
    logic             complete;
    logic             fill;
    logic [31:0]      word_full;

    assign idx       = fetch_pc[IDX_W+1:2];
    assign tag       = fetch_pc[31:IDX_W+2];
    assign slot_free = !if_valid || !stall;
    assign hit       = line_valid[idx] && (tag_mem[idx] == tag);
    assign lookup    = (state == S_IDLE) && slot_free && !br_wait && !br_done;

    // The last byte can be consumed straight off mem_rdata; if the slot is busy
    // it is parked in asm_word and recv_cnt reaches 4 while waiting.
    assign byte3_now  = (state == S_MISS) && rd_pend && (recv_cnt == 3'd3);
    assign word_ready = byte3_now || ((state == S_MISS) && (recv_cnt == 3'd4));
    assign word_full  = byte3_now ? {mem_rdata, asm_word[23:0]} : asm_word;
    assign complete   = word_ready && slot_free && !br_done;
    assign fill       = byte3_now && !br_done;

    // Next-state and memory request generation
    always_comb begin
        state_nxt = state;
        mem_re    = 1'b0;
        mem_addr  = 32'h0000_0000;
        if (state == S_MISS && issue_cnt < 3'd4) begin
            mem_re   = 1'b1;
            mem_addr = fetch_pc + {29'd0, issue_cnt};
        end
        if (br_done) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (lookup && !hit) state_nxt = S_MISS;
                S_MISS: if (complete) state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Fetch pointer, miss byte counters, output slot and cache valid bits
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc   <= RESET_PC;
            issue_cnt  <= 3'd0;
            recv_cnt   <= 3'd0;
            rd_pend    <= 1'b0;
            asm_word   <= 32'h0000_0000;
            line_valid <= '0;
            if_valid   <= 1'b0;
            pc         <= 32'h0000_0000;
            inst       <= 32'h0000_0000;
        end else if (br_done) begin
            // Redirect: any in-flight byte is orphaned by clearing rd_pend.
            fetch_pc  <= br_target & 32'hFFFF_FFFC;
            issue_cnt <= 3'd0;
            recv_cnt  <= 3'd0;
            rd_pend   <= 1'b0;
            if_valid  <= 1'b0;
        end else begin
            rd_pend <= mem_re && mem_grant;
            if (!stall) begin
                if_valid <= 1'b0;
            end
            if (fill) begin
                line_valid[idx] <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (lookup) begin
                        if (hit) begin
                            pc       <= fetch_pc;
                            inst     <= data_mem[idx];
                            if_valid <= 1'b1;
                            fetch_pc <= fetch_pc + 32'd4;
                        end else begin
                            issue_cnt <= 3'd0;
                            recv_cnt  <= 3'd0;
                        end
                    end
                end
                S_MISS: begin
                    if (mem_re && mem_grant) begin
                        issue_cnt <= issue_cnt + 3'd1;
                    end
                    if (rd_pend && recv_cnt < 3'd4) begin
                        case (recv_cnt[1:0])
                            2'd0: asm_word[7:0]   <= mem_rdata;
                            2'd1: asm_word[15:8]  <= mem_rdata;
                            2'd2: asm_word[23:16] <= mem_rdata;
                            default: asm_word[31:24] <= mem_rdata;
                        endcase
                        recv_cnt <= recv_cnt + 3'd1;
                    end
                    if (complete) begin
                        pc       <= fetch_pc;
                        inst     <= word_full;
                        if_valid <= 1'b1;
                        fetch_pc <= fetch_pc + 32'd4;
                    end
                end
                default: ;
            endcase
        end
    end

    // Cache tag/data line write when the last byte of a live miss arrives
    always_ff @(posedge clk) begin
        if (fill) begin
            tag_mem[idx]  <= tag;
            data_mem[idx] <= word_full;
        end
    end

endmodule
